ex_muldiv_unit: RTL and testbench

Multi-cycle RV32M execute-stage unit computing MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU for the instruction in EX. It is the stall-request end of the pipeline hazard interface: while an operation is in flight it raises `md_stall`, and the hazard control turns that into hold enables for PC, IF/ID, ID/EX and EX/MEM. When the operation completes it releases the stall for exactly one cycle. In that cycle it presents `md_result`, and the EX/MEM register captures it as the ALU result.

---
 rtl/md_pkg.sv | 25 ++
 rtl/md_div_core.sv | 43 ++++
 rtl/ex_muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the RV32M multiply/divide execute unit.
package md_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_ITERS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_div_core.sv
// Unsigned restoring radix-2 divider datapath; sequencing comes from load/step strobes.
module md_div_core
  import md_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_next,
  output logic [XLEN-1:0] rem_next
);

  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN:0]   shifted;
  logic            ge;

  // rem < divisor always holds, so the shifted value needs one extra bit and the
  // difference (when taken) always fits back into XLEN bits.
  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    ge       = shifted >= {1'b0, dvs_q};
    rem_next = ge ? (shifted[XLEN-1:0] - dvs_q) : shifted[XLEN-1:0];
    quo_next = {quo_q[XLEN-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M execute-stage unit: single-cycle multiply, 32-step divide, stall request to hazard control.
module ex_muldiv_unit
  import md_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            EX_md_en,
  input  logic [2:0]      EX_funct3,
  input  logic [XLEN-1:0] EX_rs1_data,
  input  logic [XLEN-1:0] EX_rs2_data,
  input  logic            flush,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  // Handshake: md_stall high means hold the pipeline; md_done pulses for one cycle,
  // with md_stall low, in the cycle md_result carries the new value.

  md_state_e       state_q, state_d;
  md_op_e          op;
  logic [4:0]      cnt_q;
  logic            sel_rem_q, q_neg_q, r_neg_q;
  logic            div_load, div_step, load_res;
  logic [XLEN-1:0] res_d;

  logic                 a_sx, b_sx, signed_div, a_neg, b_neg, div_zero, div_ovf;
  logic [2*XLEN-1:0]    ma, mb, prod;
  logic [XLEN-1:0]      mul_res, abs_a, abs_b, special_res;
  logic [XLEN-1:0]      quo_next, rem_next, q_fix, r_fix, div_res;

  always_comb begin
    op         = md_op_e'(EX_funct3);
    a_sx       = (op == OP_MULH || op == OP_MULHSU) && EX_rs1_data[XLEN-1];
    b_sx       = (op == OP_MULH) && EX_rs2_data[XLEN-1];
    ma         = {{XLEN{a_sx}}, EX_rs1_data};
    mb         = {{XLEN{b_sx}}, EX_rs2_data};
    prod       = ma * mb;
    mul_res    = (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    signed_div = !EX_funct3[0];
    a_neg      = signed_div && EX_rs1_data[XLEN-1];
    b_neg      = signed_div && EX_rs2_data[XLEN-1];
    abs_a      = a_neg ? (32'd0 - EX_rs1_data) : EX_rs1_data;
    abs_b      = b_neg ? (32'd0 - EX_rs2_data) : EX_rs2_data;
    div_zero   = (EX_rs2_data == '0);
    div_ovf    = signed_div && (EX_rs1_data == 32'h8000_0000) && (EX_rs2_data == 32'hFFFF_FFFF);
    if (div_zero) special_res = EX_funct3[1] ? EX_rs1_data : 32'hFFFF_FFFF;
    else          special_res = EX_funct3[1] ? 32'h0 : 32'h8000_0000;

    q_fix      = q_neg_q ? (32'd0 - quo_next) : quo_next;
    r_fix      = r_neg_q ? (32'd0 - rem_next) : rem_next;
    div_res    = sel_rem_q ? r_fix : q_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    div_load = 1'b0;
    div_step = 1'b0;
    load_res = 1'b0;
    res_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (EX_md_en) begin
          if (!EX_funct3[2]) begin
            load_res = 1'b1;
            res_d    = mul_res;
            state_d  = ST_DONE;
          end else if (div_zero || div_ovf) begin
            load_res = 1'b1;
            res_d    = special_res;
            state_d  = ST_DONE;
          end else begin
            div_load = 1'b1;
            state_d  = ST_DIV;
          end
        end
      end
      ST_MUL:  state_d = ST_DONE;
      ST_DIV: begin
        div_step = 1'b1;
        if (cnt_q == 5'(DIV_ITERS - 1)) begin
          load_res = 1'b1;
          res_d    = div_res;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A flush abandons whatever is in flight and leaves md_result untouched.
    if (flush) begin
      state_d  = ST_IDLE;
      div_load = 1'b0;
      div_step = 1'b0;
      load_res = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_result <= '0;
      cnt_q     <= '0;
      sel_rem_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else begin
      if (div_load) begin
        cnt_q     <= '0;
        sel_rem_q <= EX_funct3[1];
        q_neg_q   <= a_neg ^ b_neg;
        r_neg_q   <= a_neg;
      end else if (div_step) begin
        cnt_q <= cnt_q + 5'd1;
      end
      if (load_res) md_result <= res_d;
    end
  end

  md_div_core u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .step     (div_step),
    .dividend (abs_a),
    .divisor  (abs_b),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  assign md_stall = (state_q == ST_IDLE && EX_md_en && !flush) ||
                    state_q == ST_MUL || state_q == ST_DIV;
  assign md_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: arithmetic reference model checked every cycle plus literal vectors.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        EX_md_en;
  logic [2:0]  EX_funct3;
  logic [31:0] EX_rs1_data;
  logic [31:0] EX_rs2_data;
  logic        flush;
  logic        md_stall;
  logic        md_done;
  logic [31:0] md_result;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_q[$];

  ex_muldiv_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .EX_md_en    (EX_md_en),
    .EX_funct3   (EX_funct3),
    .EX_rs1_data (EX_rs1_data),
    .EX_rs2_data (EX_rs2_data),
    .flush       (flush),
    .md_stall    (md_stall),
    .md_done     (md_done),
    .md_result   (md_result)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f)
      3'b000: begin up = ua * ub; return up[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * $signed(ub); return p[63:32]; end
      3'b011: begin up = ua * ub; return up[63:32]; end
      3'b100: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'b101: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'b110: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2] || b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  bit          m_busy = 0;
  bit          m_done = 0;
  int          m_left = 0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_pend = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_left = 0; m_res = '0;
      chk("rst_result", md_result, 32'h0);
      chk("rst_done", {31'b0, md_done}, 32'h0);
      chk("rst_stall", {31'b0, md_stall}, {31'b0, EX_md_en & ~flush});
    end else begin
      chk("cyc_stall", {31'b0, md_stall}, {31'b0, m_busy | (~m_done & EX_md_en & ~flush)});
      chk("cyc_done", {31'b0, md_done}, {31'b0, m_done});
      chk("cyc_result", md_result, m_res);
      if (flush) begin
        m_busy = 0; m_done = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin m_busy = 0; m_done = 1; m_res = m_pend; end
      end else if (EX_md_en) begin
        m_pend = model_res(EX_funct3, EX_rs1_data, EX_rs2_data);
        if (model_lat(EX_funct3, EX_rs1_data, EX_rs2_data) == 1) begin
          m_done = 1; m_res = m_pend;
        end else begin
          m_busy = 1; m_left = 32;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issues one M-op, leaves EX_md_en high through DONE, and checks result/latency literals.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit, input int lat);
    int cyc, stalls;
    bit seen;
    logic [31:0] exp;
    exp_q.push_back(lit);
    chk({name, "_model"}, model_res(f, a, b), lit);
    @(posedge clk); #1;
    EX_md_en = 1'b1; EX_funct3 = f; EX_rs1_data = a; EX_rs2_data = b;
    cyc = 0; stalls = 0; seen = 0;
    while (!seen && cyc <= 40) begin
      @(negedge clk);
      if (md_done) seen = 1;
      else begin
        if (md_stall) stalls++;
        cyc++;
        if (cyc == 1) begin
          @(posedge clk); #1;
          EX_rs1_data = ~a; EX_rs2_data = a ^ b;
        end
      end
    end
    exp = exp_q.pop_front();
    if (!seen) begin
      nvec++; nerr++;
      $display("FAIL %s_timeout: got no md_done expected md_done within 40 cycles", name);
    end else begin
      chk({name, "_result"}, md_result, exp);
      chk({name, "_latency"}, cyc, lat);
      chk({name, "_stalls"}, stalls, lat);
      chk({name, "_done_stall"}, {31'b0, md_stall}, 32'h0);
    end
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    EX_md_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_done(input int n, output int dones);
    dones = 0;
    repeat (n) begin
      @(negedge clk);
      if (md_done) dones++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    rst_n = 1'b0; EX_md_en = 1'b0; EX_funct3 = '0;
    EX_rs1_data = '0; EX_rs2_data = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_result", md_result, 32'h0);
    chk("reset_done", {31'b0, md_done}, 32'h0);
    chk("reset_stall", {31'b0, md_stall}, 32'h0);

    // Back-to-back operations: each starts in the cycle after the previous DONE.
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
    run_op("mul",    3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
    go_idle(2);
    run_op("divu0",  3'b101, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1);
    run_op("remu0",  3'b111, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1);
    run_op("div0",   3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("divu",   3'b101, 32'd100,       32'd7,         32'd14,        33);
    run_op("remu",   3'b111, 32'd100,       32'd7,         32'd2,         33);
    run_op("divneg", 3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("remneg", 3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33);
    run_op("divuhi", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         33);
    go_idle(2);

    // Flush at cycle 10 of a divide: no done pulse, result held.
    @(posedge clk); #1;
    EX_md_en = 1'b1; EX_funct3 = 3'b100; EX_rs1_data = 32'd1000; EX_rs2_data = 32'd3;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; EX_md_en = 1'b0;
    @(negedge clk);
    chk("flush_stall", {31'b0, md_stall}, 32'h0);
    chk("flush_result", md_result, 32'h0);
    count_done(40, dones);
    chk("flush_no_done", dones, 0);
    run_op("mul67",  3'b000, 32'd6, 32'd7, 32'd42, 1);
    go_idle(1);

    // Asynchronous reset at cycle 5 of a divide.
    @(posedge clk); #1;
    EX_md_en = 1'b1; EX_funct3 = 3'b101; EX_rs1_data = 32'd500; EX_rs2_data = 32'd9;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0; EX_md_en = 1'b0;
    #1;
    chk("arst_result", md_result, 32'h0);
    chk("arst_stall", {31'b0, md_stall}, 32'h0);
    chk("arst_done", {31'b0, md_done}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    count_done(40, dones);
    chk("arst_no_done", dones, 0);
    run_op("post_rst", 3'b111, 32'd500, 32'd9, 32'd5, 33);
    go_idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
